// File: rtl/id_stage_pipe.sv
// Pipelined ID stage: decodes logic/immediate/shift ops and resolves operands.
// Forwards from EX/MEM, inserts bubbles on load-use, and registers the EX bundle.
module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid_in,
    output logic               if_ready_out,
    input  logic [31:0]        inst_in,
    output logic [RADDR_W-1:0] rd_addr1_out,
    output logic [RADDR_W-1:0] rd_addr2_out,
    output logic               rd_en1_out,
    output logic               rd_en2_out,
    input  logic [DATA_W-1:0]  rd_data1_in,
    input  logic [DATA_W-1:0]  rd_data2_in,
    input  logic               ex_wr_en_in,
    input  logic [RADDR_W-1:0] ex_wr_addr_in,
    input  logic [DATA_W-1:0]  ex_wr_data_in,
    input  logic               ex_is_load_in,
    input  logic               mem_wr_en_in,
    input  logic [RADDR_W-1:0] mem_wr_addr_in,
    input  logic [DATA_W-1:0]  mem_wr_data_in,
    output logic               ex_valid_out,
    input  logic               ex_ready_in,
    output logic [7:0]         aluop_out,
    output logic [2:0]         alusel_out,
    output logic [DATA_W-1:0]  src1_out,
    output logic [DATA_W-1:0]  src2_out,
    output logic [RADDR_W-1:0] wr_addr_out,
    output logic               wr_en_out,
    output logic               inst_invalid_out,
    output logic [CNT_W-1:0]   stall_cnt_out
);

    localparam logic [7:0] EXE_OP_NOP  = 8'h00;
    localparam logic [7:0] EXE_OP_AND  = 8'h24;
    localparam logic [7:0] EXE_OP_OR   = 8'h25;
    localparam logic [7:0] EXE_OP_XOR  = 8'h26;
    localparam logic [7:0] EXE_OP_NOR  = 8'h27;
    localparam logic [7:0] EXE_OP_SLL  = 8'h7C;
    localparam logic [7:0] EXE_OP_SRL  = 8'h02;
    localparam logic [7:0] EXE_OP_SRA  = 8'h03;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    logic [5:0]  op, funct;
    logic [15:0] imm;
    logic [4:0]  sa;
    logic [RADDR_W-1:0] rs, rt, rd;

    assign op    = inst_in[31:26];
    assign rs    = RADDR_W'(inst_in[25:21]);
    assign rt    = RADDR_W'(inst_in[20:16]);
    assign rd    = RADDR_W'(inst_in[15:11]);
    assign sa    = inst_in[10:6];
    assign funct = inst_in[5:0];
    assign imm   = inst_in[15:0];

    logic [7:0]         d_aluop;
    logic [2:0]         d_alusel;
    logic [RADDR_W-1:0] d_wa;
    logic               d_we, d_inv, re1, re2;
    logic               use_imm, use_sa, is_lui, is_shift;

    always_comb begin
        d_aluop  = EXE_OP_NOP;
        d_alusel = EXE_RES_NOP;
        d_wa     = '0;
        d_we     = 1'b0;
        d_inv    = 1'b1;
        re1      = 1'b0;
        re2      = 1'b0;
        use_imm  = 1'b0;
        use_sa   = 1'b0;
        is_lui   = 1'b0;
        is_shift = 1'b0;
        case (op)
            6'h0C, 6'h0D, 6'h0E: begin
                re1      = 1'b1;
                use_imm  = 1'b1;
                d_wa     = rt;
                d_we     = 1'b1;
                d_inv    = 1'b0;
                d_alusel = EXE_RES_LOGIC;
                d_aluop  = (op == 6'h0C) ? EXE_OP_AND :
                           (op == 6'h0D) ? EXE_OP_OR : EXE_OP_XOR;
            end
            6'h0F: begin
                is_lui   = 1'b1;
                d_wa     = rt;
                d_we     = 1'b1;
                d_inv    = 1'b0;
                d_alusel = EXE_RES_LOGIC;
                d_aluop  = EXE_OP_OR;
            end
            6'h00: begin
                case (funct)
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        re1      = 1'b1;
                        re2      = 1'b1;
                        d_wa     = rd;
                        d_we     = 1'b1;
                        d_inv    = 1'b0;
                        d_alusel = EXE_RES_LOGIC;
                        d_aluop  = {2'b00, funct};
                    end
                    6'h00, 6'h02, 6'h03: begin
                        re2      = 1'b1;
                        is_shift = 1'b1;
                        use_sa   = 1'b1;
                        d_wa     = rd;
                        d_we     = 1'b1;
                        d_inv    = 1'b0;
                        d_alusel = EXE_RES_SHIFT;
                        d_aluop  = (funct == 6'h00) ? EXE_OP_SLL :
                                   (funct == 6'h02) ? EXE_OP_SRL : EXE_OP_SRA;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign rd_en1_out   = rst_n & re1;
    assign rd_en2_out   = rst_n & re2;
    assign rd_addr1_out = rst_n ? rs : '0;
    assign rd_addr2_out = rst_n ? rt : '0;

    logic fwd_on;
    assign fwd_on = (FWD_EN != 0);

    // A load in EX has no data yet, so it never forwards.
    function automatic logic [DATA_W-1:0] resolve(
        input logic               en,
        input logic [RADDR_W-1:0] a,
        input logic [DATA_W-1:0]  rf
    );
        if (!en || a == '0)
            return '0;
        if (fwd_on && ex_wr_en_in && ex_wr_addr_in == a && !ex_is_load_in)
            return ex_wr_data_in;
        if (fwd_on && mem_wr_en_in && mem_wr_addr_in == a)
            return mem_wr_data_in;
        return rf;
    endfunction

    logic [DATA_W-1:0] opd1, opd2, n_src1, n_src2;

    assign opd1 = resolve(rd_en1_out, rs, rd_data1_in);
    assign opd2 = resolve(rd_en2_out, rt, rd_data2_in);

    assign n_src1 = is_lui   ? DATA_W'({imm, 16'h0000}) :
                    is_shift ? opd2 : opd1;
    assign n_src2 = use_imm ? DATA_W'(imm) :
                    use_sa  ? DATA_W'(sa)  :
                    is_lui  ? '0 : opd2;

    logic m_ex1, m_ex2, m_mem1, m_mem2, hazard, advance, take;

    assign m_ex1  = rd_en1_out & ex_wr_en_in & (ex_wr_addr_in != '0)
                  & (ex_wr_addr_in == rs);
    assign m_ex2  = rd_en2_out & ex_wr_en_in & (ex_wr_addr_in != '0)
                  & (ex_wr_addr_in == rt);
    assign m_mem1 = rd_en1_out & mem_wr_en_in & (mem_wr_addr_in != '0)
                  & (mem_wr_addr_in == rs);
    assign m_mem2 = rd_en2_out & mem_wr_en_in & (mem_wr_addr_in != '0)
                  & (mem_wr_addr_in == rt);

    assign hazard = if_valid_in & (fwd_on
                  ? (ex_is_load_in & (m_ex1 | m_ex2))
                  : (m_ex1 | m_ex2 | m_mem1 | m_mem2));

    assign advance      = !ex_valid_out | ex_ready_in;
    assign take         = if_valid_in & !hazard;
    assign if_ready_out = rst_n & !hazard & advance;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_out     <= 1'b0;
            aluop_out        <= EXE_OP_NOP;
            alusel_out       <= EXE_RES_NOP;
            src1_out         <= '0;
            src2_out         <= '0;
            wr_addr_out      <= '0;
            wr_en_out        <= 1'b0;
            inst_invalid_out <= 1'b0;
            stall_cnt_out    <= '0;
        end else if (advance) begin
            ex_valid_out <= take;
            if (take) begin
                aluop_out        <= d_aluop;
                alusel_out       <= d_alusel;
                src1_out         <= n_src1;
                src2_out         <= n_src2;
                wr_addr_out      <= d_wa;
                wr_en_out        <= d_we;
                inst_invalid_out <= d_inv;
            end
            if (hazard && stall_cnt_out != '1)
                stall_cnt_out <= stall_cnt_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, hazards, backpressure.
// A second instance with CNT_W = 2 covers stall-counter saturation.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_in;
    logic        if_ready_out;
    logic [31:0] inst_in;
    logic [4:0]  rd_addr1_out, rd_addr2_out;
    logic        rd_en1_out, rd_en2_out;
    logic [31:0] rd_data1_in, rd_data2_in;
    logic        ex_wr_en_in, ex_is_load_in;
    logic [4:0]  ex_wr_addr_in;
    logic [31:0] ex_wr_data_in;
    logic        mem_wr_en_in;
    logic [4:0]  mem_wr_addr_in;
    logic [31:0] mem_wr_data_in;
    logic        ex_valid_out, ex_ready_in;
    logic [7:0]  aluop_out;
    logic [2:0]  alusel_out;
    logic [31:0] src1_out, src2_out;
    logic [4:0]  wr_addr_out;
    logic        wr_en_out, inst_invalid_out;
    logic [15:0] stall_cnt_out;

    logic        d2_if_ready;
    logic [4:0]  d2_ra1, d2_ra2;
    logic        d2_re1, d2_re2, d2_valid;
    logic [7:0]  d2_aluop;
    logic [2:0]  d2_alusel;
    logic [31:0] d2_src1, d2_src2;
    logic [4:0]  d2_wa;
    logic        d2_we, d2_inv;
    logic [1:0]  d2_stall;

    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        rd_data1_in = rf[rd_addr1_out];
        rd_data2_in = rf[rd_addr2_out];
    end

    id_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_in(if_valid_in), .if_ready_out(if_ready_out),
        .inst_in(inst_in),
        .rd_addr1_out(rd_addr1_out), .rd_addr2_out(rd_addr2_out),
        .rd_en1_out(rd_en1_out), .rd_en2_out(rd_en2_out),
        .rd_data1_in(rd_data1_in), .rd_data2_in(rd_data2_in),
        .ex_wr_en_in(ex_wr_en_in), .ex_wr_addr_in(ex_wr_addr_in),
        .ex_wr_data_in(ex_wr_data_in), .ex_is_load_in(ex_is_load_in),
        .mem_wr_en_in(mem_wr_en_in), .mem_wr_addr_in(mem_wr_addr_in),
        .mem_wr_data_in(mem_wr_data_in),
        .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
        .aluop_out(aluop_out), .alusel_out(alusel_out),
        .src1_out(src1_out), .src2_out(src2_out),
        .wr_addr_out(wr_addr_out), .wr_en_out(wr_en_out),
        .inst_invalid_out(inst_invalid_out), .stall_cnt_out(stall_cnt_out)
    );

    id_stage_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .if_valid_in(if_valid_in), .if_ready_out(d2_if_ready),
        .inst_in(inst_in),
        .rd_addr1_out(d2_ra1), .rd_addr2_out(d2_ra2),
        .rd_en1_out(d2_re1), .rd_en2_out(d2_re2),
        .rd_data1_in(rd_data1_in), .rd_data2_in(rd_data2_in),
        .ex_wr_en_in(ex_wr_en_in), .ex_wr_addr_in(ex_wr_addr_in),
        .ex_wr_data_in(ex_wr_data_in), .ex_is_load_in(ex_is_load_in),
        .mem_wr_en_in(mem_wr_en_in), .mem_wr_addr_in(mem_wr_addr_in),
        .mem_wr_data_in(mem_wr_data_in),
        .ex_valid_out(d2_valid), .ex_ready_in(ex_ready_in),
        .aluop_out(d2_aluop), .alusel_out(d2_alusel),
        .src1_out(d2_src1), .src2_out(d2_src2),
        .wr_addr_out(d2_wa), .wr_en_out(d2_we),
        .inst_invalid_out(d2_inv), .stall_cnt_out(d2_stall)
    );

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
        input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ex_wr_en_in = 0; ex_wr_addr_in = 0; ex_wr_data_in = 0; ex_is_load_in = 0;
        mem_wr_en_in = 0; mem_wr_addr_in = 0; mem_wr_data_in = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; if_valid_in = 1; ex_ready_in = 1;
        inst_in = itype(6'h0D, 5'd1, 5'd3, 16'h1100);
        idle_bus();
        step(); step();
        checks++; if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", ex_valid_out); end
        checks++; if (aluop_out !== 8'h00 || alusel_out !== 3'd0) begin failures++; $display("FAIL rst_op got=%0h/%0h exp=0/0", aluop_out, alusel_out); end
        checks++; if (src1_out !== 0 || src2_out !== 0 || stall_cnt_out !== 0) begin failures++; $display("FAIL rst_data got=%0h/%0h/%0h exp=0", src1_out, src2_out, stall_cnt_out); end
        checks++; if (rd_en1_out !== 0 || rd_addr1_out !== 0 || if_ready_out !== 0) begin failures++; $display("FAIL rst_comb got=%0h/%0h/%0h exp=0/0/0", rd_en1_out, rd_addr1_out, if_ready_out); end
        if_valid_in = 0;
        rst_n = 1;
        step();
    endtask

    task automatic test_ori();
        rf[1] = 32'h0000_0020;
        if_valid_in = 1;
        inst_in = itype(6'h0D, 5'd1, 5'd3, 16'h1100);
        #1;
        checks++; if (if_ready_out !== 1 || rd_en1_out !== 1 || rd_addr1_out !== 5'd1) begin failures++; $display("FAIL ori_comb got=%0h/%0h/%0h exp=1/1/1", if_ready_out, rd_en1_out, rd_addr1_out); end
        step();
        if_valid_in = 0;
        checks++; if (ex_valid_out !== 1 || aluop_out !== 8'h25 || alusel_out !== 3'd1) begin failures++; $display("FAIL ori_op got=%0h/%0h/%0h exp=1/25/1", ex_valid_out, aluop_out, alusel_out); end
        checks++; if (src1_out !== 32'h20 || src2_out !== 32'h1100) begin failures++; $display("FAIL ori_src got=%0h/%0h exp=20/1100", src1_out, src2_out); end
        checks++; if (wr_addr_out !== 5'd3 || wr_en_out !== 1 || inst_invalid_out !== 0) begin failures++; $display("FAIL ori_dst got=%0h/%0h/%0h exp=3/1/0", wr_addr_out, wr_en_out, inst_invalid_out); end
        step();
    endtask

    task automatic test_forward();
        rf[1] = 32'h0000_0020; rf[2] = 32'h0000_5555;
        ex_wr_en_in = 1; ex_wr_addr_in = 1; ex_wr_data_in = 32'hAAAA_0000;
        mem_wr_en_in = 1; mem_wr_addr_in = 1; mem_wr_data_in = 32'h1;
        if_valid_in = 1;
        inst_in = rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h25);
        step();
        checks++; if (src1_out !== 32'hAAAA_0000 || src2_out !== 32'h5555) begin failures++; $display("FAIL fwd_ex got=%0h/%0h exp=aaaa0000/5555", src1_out, src2_out); end
        checks++; if (wr_addr_out !== 5'd5 || aluop_out !== 8'h25) begin failures++; $display("FAIL fwd_dst got=%0h/%0h exp=5/25", wr_addr_out, aluop_out); end
        ex_wr_en_in = 0;
        inst_in = rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h27);
        step();
        checks++; if (src1_out !== 32'h1 || aluop_out !== 8'h27) begin failures++; $display("FAIL fwd_mem got=%0h/%0h exp=1/27", src1_out, aluop_out); end
        ex_wr_en_in = 1; ex_wr_addr_in = 0; ex_wr_data_in = 32'hFFFF;
        mem_wr_en_in = 0;
        inst_in = rtype(5'd0, 5'd2, 5'd9, 5'd0, 6'h26);
        step();
        if_valid_in = 0;
        idle_bus();
        checks++; if (src1_out !== 32'h0 || src2_out !== 32'h5555) begin failures++; $display("FAIL fwd_r0 got=%0h/%0h exp=0/5555", src1_out, src2_out); end
        step();
    endtask

    task automatic test_load_use();
        rf[4] = 32'hDEAD;
        ex_wr_en_in = 1; ex_wr_addr_in = 4; ex_wr_data_in = 32'h9999; ex_is_load_in = 1;
        if_valid_in = 1;
        inst_in = itype(6'h0C, 5'd4, 5'd6, 16'h00FF);
        #1;
        checks++; if (if_ready_out !== 0) begin failures++; $display("FAIL lu_ready got=%0h exp=0", if_ready_out); end
        step();
        checks++; if (ex_valid_out !== 0 || stall_cnt_out !== 16'd1) begin failures++; $display("FAIL lu_bubble got=%0h/%0h exp=0/1", ex_valid_out, stall_cnt_out); end
        idle_bus();
        mem_wr_en_in = 1; mem_wr_addr_in = 4; mem_wr_data_in = 32'h1234;
        #1;
        checks++; if (if_ready_out !== 1) begin failures++; $display("FAIL lu_release got=%0h exp=1", if_ready_out); end
        step();
        if_valid_in = 0;
        idle_bus();
        checks++; if (ex_valid_out !== 1 || src1_out !== 32'h1234 || src2_out !== 32'hFF || aluop_out !== 8'h24) begin failures++; $display("FAIL lu_fwd got=%0h/%0h/%0h/%0h exp=1/1234/ff/24", ex_valid_out, src1_out, src2_out, aluop_out); end
        checks++; if (stall_cnt_out !== 16'd1 || wr_addr_out !== 5'd6) begin failures++; $display("FAIL lu_cnt got=%0h/%0h exp=1/6", stall_cnt_out, wr_addr_out); end
        step();
    endtask

    task automatic test_backpressure();
        rf[1] = 32'h0000_0020;
        if_valid_in = 1;
        inst_in = itype(6'h0E, 5'd1, 5'd7, 16'h0F0F);
        step();
        checks++; if (ex_valid_out !== 1 || aluop_out !== 8'h26 || src2_out !== 32'h0F0F) begin failures++; $display("FAIL bp_load got=%0h/%0h/%0h exp=1/26/f0f", ex_valid_out, aluop_out, src2_out); end
        ex_ready_in = 0;
        inst_in = itype(6'h0D, 5'd1, 5'd10, 16'h00AA);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_ready_out !== 0) begin failures++; $display("FAIL bp_ready%0d got=%0h exp=0", i, if_ready_out); end
            step();
            checks++; if (ex_valid_out !== 1 || aluop_out !== 8'h26 || src1_out !== 32'h20 || src2_out !== 32'h0F0F || wr_addr_out !== 5'd7) begin failures++; $display("FAIL bp_hold%0d got=%0h/%0h/%0h/%0h exp=1/26/f0f/7", i, ex_valid_out, aluop_out, src2_out, wr_addr_out); end
        end
        ex_ready_in = 1;
        #1;
        checks++; if (if_ready_out !== 1) begin failures++; $display("FAIL bp_release got=%0h exp=1", if_ready_out); end
        step();
        if_valid_in = 0;
        checks++; if (ex_valid_out !== 1 || aluop_out !== 8'h25 || src2_out !== 32'hAA || wr_addr_out !== 5'd10) begin failures++; $display("FAIL bp_next got=%0h/%0h/%0h/%0h exp=1/25/aa/a", ex_valid_out, aluop_out, src2_out, wr_addr_out); end
        step();
    endtask

    task automatic test_decode();
        if_valid_in = 1;
        inst_in = {6'h3F, 26'h0AB_CDEF};
        step();
        checks++; if (ex_valid_out !== 1 || inst_invalid_out !== 1 || wr_en_out !== 0 || aluop_out !== 8'h00 || alusel_out !== 3'd0) begin failures++; $display("FAIL inv got=%0h/%0h/%0h/%0h/%0h exp=1/1/0/0/0", ex_valid_out, inst_invalid_out, wr_en_out, aluop_out, alusel_out); end
        rf[7] = 32'hDEAD_0001;
        inst_in = rtype(5'd0, 5'd7, 5'd2, 5'd4, 6'h00);
        #1;
        checks++; if (rd_en1_out !== 0 || rd_en2_out !== 1) begin failures++; $display("FAIL sll_en got=%0h/%0h exp=0/1", rd_en1_out, rd_en2_out); end
        step();
        checks++; if (src1_out !== 32'hDEAD_0001 || src2_out !== 32'd4 || alusel_out !== 3'd2 || aluop_out !== 8'h7C) begin failures++; $display("FAIL sll got=%0h/%0h/%0h/%0h exp=dead0001/4/2/7c", src1_out, src2_out, alusel_out, aluop_out); end
        checks++; if (wr_addr_out !== 5'd2 || wr_en_out !== 1 || inst_invalid_out !== 0) begin failures++; $display("FAIL sll_dst got=%0h/%0h/%0h exp=2/1/0", wr_addr_out, wr_en_out, inst_invalid_out); end
        inst_in = rtype(5'd0, 5'd7, 5'd3, 5'd31, 6'h03);
        step();
        checks++; if (aluop_out !== 8'h03 || src2_out !== 32'd31 || wr_addr_out !== 5'd3) begin failures++; $display("FAIL sra got=%0h/%0h/%0h exp=3/1f/3", aluop_out, src2_out, wr_addr_out); end
        inst_in = itype(6'h0F, 5'd1, 5'd9, 16'hABCD);
        step();
        if_valid_in = 0;
        checks++; if (src1_out !== 32'hABCD_0000 || src2_out !== 0 || aluop_out !== 8'h25 || wr_addr_out !== 5'd9) begin failures++; $display("FAIL lui got=%0h/%0h/%0h/%0h exp=abcd0000/0/25/9", src1_out, src2_out, aluop_out, wr_addr_out); end
    endtask

    task automatic test_reset_mid();
        checks++; if (ex_valid_out !== 1 || stall_cnt_out !== 16'd1) begin failures++; $display("FAIL mid_pre got=%0h/%0h exp=1/1", ex_valid_out, stall_cnt_out); end
        rst_n = 0;
        if_valid_in = 1;
        inst_in = itype(6'h0D, 5'd1, 5'd3, 16'h1100);
        step();
        checks++; if (ex_valid_out !== 0 || aluop_out !== 0 || alusel_out !== 0 || src1_out !== 0 || src2_out !== 0) begin failures++; $display("FAIL mid_rst got=%0h/%0h/%0h/%0h/%0h exp=0", ex_valid_out, aluop_out, alusel_out, src1_out, src2_out); end
        checks++; if (wr_addr_out !== 0 || wr_en_out !== 0 || inst_invalid_out !== 0 || stall_cnt_out !== 0 || d2_stall !== 0) begin failures++; $display("FAIL mid_rst2 got=%0h/%0h/%0h/%0h/%0h exp=0", wr_addr_out, wr_en_out, inst_invalid_out, stall_cnt_out, d2_stall); end
        if_valid_in = 0;
        rst_n = 1;
        step();
    endtask

    task automatic test_saturate();
        ex_wr_en_in = 1; ex_wr_addr_in = 4; ex_is_load_in = 1;
        if_valid_in = 1;
        inst_in = itype(6'h0C, 5'd4, 5'd6, 16'h00FF);
        for (int i = 0; i < 5; i++) step();
        checks++; if (d2_stall !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0h exp=3", d2_stall); end
        checks++; if (stall_cnt_out !== 16'd5) begin failures++; $display("FAIL sat_cnt16 got=%0h exp=5", stall_cnt_out); end
        step();
        checks++; if (d2_stall !== 2'd3 || d2_valid !== 0) begin failures++; $display("FAIL sat_hold got=%0h/%0h exp=3/0", d2_stall, d2_valid); end
        if_valid_in = 0;
        idle_bus();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        test_reset();
        test_ori();
        test_forward();
        test_load_use();
        test_backpressure();
        test_decode();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
